// File: rtl/pm_jtag_tap_ctrl.sv
// pm_jtag_tap_ctrl: IEEE 1149.1 TAP controller for the PM JTAG port (IR, IDCODE/BYPASS/USER decode, TDO mux).
// Latency: state/IR shift/BYPASS update on posedge reg_tck; ir_active, reg_tdo, reg_tdo_en update on negedge reg_tck.
// Backpressure: none, the JTAG pins are the pacing clock. Optional USER DR enabled by defining PM_TAP_USER_DR_EN.
module pm_jtag_tap_ctrl #(
  parameter int                    IR_LENGTH     = 4,
  parameter logic [IR_LENGTH-1:0]  IR_CAPTURE    = 4'b0001,
  parameter logic [IR_LENGTH-1:0]  IDCODE_OPCODE = 4'b0010,
  parameter logic [IR_LENGTH-1:0]  USER_OPCODE   = 4'b1000,
  parameter logic [IR_LENGTH-1:0]  BYPASS_OPCODE = 4'b1111
) (
  input  logic                 reg_tck,
  input  logic                 reg_rst_n,
  input  logic                 reg_tms,
  input  logic                 reg_tdi,
  output logic                 reg_tdo,
  output logic                 reg_tdo_en,
  output logic                 idcode_capture_en,
  output logic                 idcode_shift_enable,
  input  logic                 idcode_tdo,
  output logic                 user_capture_en,
  output logic                 user_shift_enable,
  output logic                 user_update_en,
  input  logic                 user_tdo,
  output logic [3:0]           tap_state,
  output logic [IR_LENGTH-1:0] ir_active
);

  typedef enum logic [3:0] {
    TLR      = 4'h0,
    RTI      = 4'h1,
    SEL_DR   = 4'h2,
    CAP_DR   = 4'h3,
    SH_DR    = 4'h4,
    EX1_DR   = 4'h5,
    PAUSE_DR = 4'h6,
    EX2_DR   = 4'h7,
    UPD_DR   = 4'h8,
    SEL_IR   = 4'h9,
    CAP_IR   = 4'hA,
    SH_IR    = 4'hB,
    EX1_IR   = 4'hC,
    PAUSE_IR = 4'hD,
    EX2_IR   = 4'hE,
    UPD_IR   = 4'hF
  } tap_state_e;

  tap_state_e            state, state_nxt;
  logic [IR_LENGTH-1:0]  ir_shift;
  logic                  bypass_bit;
  logic                  sel_idcode;
  logic                  sel_user;
  logic                  sel_bypass;
  logic                  dr_tdo;

  // Every opcode that is not IDCODE (or USER when built in) falls through to BYPASS,
  // so BYPASS_OPCODE itself needs no explicit compare.
  assign sel_idcode = (ir_active == IDCODE_OPCODE);
`ifdef PM_TAP_USER_DR_EN
  assign sel_user   = (ir_active == USER_OPCODE);
`else
  assign sel_user   = 1'b0;
  logic unused_user_tdo;
  assign unused_user_tdo = user_tdo;
`endif
  assign sel_bypass = !sel_idcode && !sel_user;
  assign tap_state  = state;

  // TAP state register, TRST_N forces Test-Logic-Reset
  always_ff @(posedge reg_tck or negedge reg_rst_n) begin
    if (!reg_rst_n) state <= TLR;
    else            state <= state_nxt;
  end

  // 1149.1 next-state function on TMS
  always_comb begin
    state_nxt = state;
    unique case (state)
      TLR:      state_nxt = reg_tms ? TLR    : RTI;
      RTI:      state_nxt = reg_tms ? SEL_DR : RTI;
      SEL_DR:   state_nxt = reg_tms ? SEL_IR : CAP_DR;
      CAP_DR:   state_nxt = reg_tms ? EX1_DR : SH_DR;
      SH_DR:    state_nxt = reg_tms ? EX1_DR : SH_DR;
      EX1_DR:   state_nxt = reg_tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_nxt = reg_tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_nxt = reg_tms ? UPD_DR : SH_DR;
      UPD_DR:   state_nxt = reg_tms ? SEL_DR : RTI;
      SEL_IR:   state_nxt = reg_tms ? TLR    : CAP_IR;
      CAP_IR:   state_nxt = reg_tms ? EX1_IR : SH_IR;
      SH_IR:    state_nxt = reg_tms ? EX1_IR : SH_IR;
      EX1_IR:   state_nxt = reg_tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_nxt = reg_tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_nxt = reg_tms ? UPD_IR : SH_IR;
      UPD_IR:   state_nxt = reg_tms ? SEL_DR : RTI;
      default:  state_nxt = TLR;
    endcase
  end

  // Data-register strobes, decoded purely from registered state and ir_active
  always_comb begin
    idcode_capture_en   = 1'b0;
    idcode_shift_enable = 1'b0;
    user_capture_en     = 1'b0;
    user_shift_enable   = 1'b0;
    user_update_en      = 1'b0;
    if (sel_idcode) begin
      idcode_capture_en   = (state == CAP_DR);
      idcode_shift_enable = (state == SH_DR);
    end
    if (sel_user) begin
      user_capture_en   = (state == CAP_DR);
      user_shift_enable = (state == SH_DR);
      user_update_en    = (state == UPD_DR);
    end
  end

  // IR shift stage: capture fixed pattern, shift LSB-out / TDI-in
  always_ff @(posedge reg_tck or negedge reg_rst_n) begin
    if (!reg_rst_n)             ir_shift <= IR_CAPTURE;
    else if (state == CAP_IR)   ir_shift <= IR_CAPTURE;
    else if (state == SH_IR)    ir_shift <= {reg_tdi, ir_shift[IR_LENGTH-1:1]};
  end

  // Active instruction: loaded mid-cycle in Update-IR, forced to IDCODE in Test-Logic-Reset
  always_ff @(negedge reg_tck or negedge reg_rst_n) begin
    if (!reg_rst_n)           ir_active <= IDCODE_OPCODE;
    else if (state == TLR)    ir_active <= IDCODE_OPCODE;
    else if (state == UPD_IR) ir_active <= ir_shift;
  end

  // 1-bit BYPASS register: captures 0 so a scan can tell it apart from IDCODE (bit0 = 1)
  always_ff @(posedge reg_tck or negedge reg_rst_n) begin
    if (!reg_rst_n)                        bypass_bit <= 1'b0;
    else if (sel_bypass && state == CAP_DR) bypass_bit <= 1'b0;
    else if (sel_bypass && state == SH_DR)  bypass_bit <= reg_tdi;
  end

  // Serial source for the currently selected data register
  always_comb begin
    dr_tdo = bypass_bit;
    if (sel_idcode)    dr_tdo = idcode_tdo;
    else if (sel_user) dr_tdo = user_tdo;
  end

  // TDO launched on the falling edge; holds its last value while not shifting
  always_ff @(negedge reg_tck or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      reg_tdo    <= 1'b0;
      reg_tdo_en <= 1'b0;
    end else if (state == SH_IR) begin
      reg_tdo    <= ir_shift[0];
      reg_tdo_en <= 1'b1;
    end else if (state == SH_DR) begin
      reg_tdo    <= dr_tdo;
      reg_tdo_en <= 1'b1;
    end else begin
      reg_tdo_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pm_jtag_tap_ctrl.sv
// tb_pm_jtag_tap_ctrl: scoreboard bench for pm_jtag_tap_ctrl.
// Expected TDO bits are queued as TMS/TDI are driven and popped whenever reg_tdo_en is high.
// Define PM_TAP_USER_DR_EN for both DUT and bench to exercise the USER register.
module tb_pm_jtag_tap_ctrl;

`ifdef PM_TAP_USER_DR_EN
  localparam logic USER_EN = 1'b1;
`else
  localparam logic USER_EN = 1'b0;
`endif
  localparam logic [31:0] IDCODE_VAL = 32'hBA20A005;

  logic       reg_tck = 1'b0;
  logic       reg_rst_n;
  logic       reg_tms;
  logic       reg_tdi;
  logic       reg_tdo;
  logic       reg_tdo_en;
  logic       idcode_capture_en;
  logic       idcode_shift_enable;
  logic       idcode_tdo;
  logic       user_capture_en;
  logic       user_shift_enable;
  logic       user_update_en;
  logic       user_tdo;
  logic [3:0] tap_state;
  logic [3:0] ir_active;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];
  logic [31:0] id_sr = 32'h0;

  pm_jtag_tap_ctrl dut (
    .reg_tck             (reg_tck),
    .reg_rst_n           (reg_rst_n),
    .reg_tms             (reg_tms),
    .reg_tdi             (reg_tdi),
    .reg_tdo             (reg_tdo),
    .reg_tdo_en          (reg_tdo_en),
    .idcode_capture_en   (idcode_capture_en),
    .idcode_shift_enable (idcode_shift_enable),
    .idcode_tdo          (idcode_tdo),
    .user_capture_en     (user_capture_en),
    .user_shift_enable   (user_shift_enable),
    .user_update_en      (user_update_en),
    .user_tdo            (user_tdo),
    .tap_state           (tap_state),
    .ir_active           (ir_active)
  );

  always #5 reg_tck = ~reg_tck;

  // External IDCODE register driven by the DUT strobes
  always @(posedge reg_tck) begin
    if (idcode_capture_en)        id_sr <= IDCODE_VAL;
    else if (idcode_shift_enable) id_sr <= {1'b0, id_sr[31:1]};
  end
  assign idcode_tdo = id_sr[0];
  assign user_tdo   = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One TCK cycle; observe just after the falling edge and pop the scoreboard on shifted bits
  task automatic tick(input logic tms, input logic tdi);
    reg_tms = tms;
    reg_tdi = tdi;
    @(posedge reg_tck);
    @(negedge reg_tck);
    #1;
    if (reg_tdo_en) begin
      if (exp_q.size() == 0) chk("tdo_unexpected", {31'b0, reg_tdo_en}, 32'd0);
      else                   chk("tdo", {31'b0, reg_tdo}, {31'b0, exp_q.pop_front()});
    end
  endtask

  task automatic sb_empty(input string tag);
    chk(tag, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    reg_rst_n = 1'b0;
    reg_tms   = 1'b1;
    reg_tdi   = 1'b0;
    #12;
    chk("rst_state",  {28'b0, tap_state}, 32'h0);
    chk("rst_ir",     {28'b0, ir_active}, 32'h2);
    chk("rst_tdo",    {31'b0, reg_tdo}, 32'h0);
    chk("rst_tdo_en", {31'b0, reg_tdo_en}, 32'h0);
    chk("rst_strobes", {27'b0, idcode_capture_en, idcode_shift_enable,
                        user_capture_en, user_shift_enable, user_update_en}, 32'h0);
    @(negedge reg_tck); #1;
    reg_rst_n = 1'b1;
    tick(1, 0);

    // IDCODE scan: 32 bits LSB first
    for (int i = 0; i < 32; i++) exp_q.push_back(IDCODE_VAL[i]);
    tick(0, 0); tick(1, 0); tick(0, 0);
    chk("capdr_state", {28'b0, tap_state}, 32'h3);
    chk("id_cap_en", {31'b0, idcode_capture_en}, 32'h1);
    chk("capdr_tdo_en", {31'b0, reg_tdo_en}, 32'h0);
    tick(0, 0);
    chk("id_sh_en", {31'b0, idcode_shift_enable}, 32'h1);
    for (int i = 0; i < 31; i++) tick(0, 0);
    tick(1, 0);
    chk("ex1dr_state", {28'b0, tap_state}, 32'h5);
    chk("ex1dr_tdo_en", {31'b0, reg_tdo_en}, 32'h0);
    sb_empty("idcode_bits");

    // Load BYPASS (1111); IR capture pattern comes out first
    tick(1, 0); tick(1, 0); tick(1, 0); tick(0, 0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    tick(0, 0);
    tick(0, 1); tick(0, 1); tick(0, 1); tick(1, 1);
    chk("ir_hold_ex1ir", {28'b0, ir_active}, 32'h2);
    tick(1, 0);
    chk("updir_state", {28'b0, tap_state}, 32'hF);
    chk("ir_bypass", {28'b0, ir_active}, 32'hF);
    sb_empty("ircap_bits");

    // BYPASS scan: TDI 1,0,1,1 -> TDO 0,1,0,1
    tick(1, 0); tick(0, 0);
    chk("byp_id_cap", {31'b0, idcode_capture_en}, 32'h0);
    begin
      logic [3:0] pat;
      pat = 4'b1101;
      exp_q.push_back(1'b0);
      for (int i = 0; i < 3; i++) exp_q.push_back(pat[i]);
      tick(0, 0);
      chk("byp_id_sh", {31'b0, idcode_shift_enable}, 32'h0);
      for (int i = 0; i < 3; i++) tick(0, pat[i]);
      tick(1, pat[3]);
    end
    sb_empty("bypass_bits");

    // Pause and resume without recapture: last shifted TDI (1) reappears
    tick(0, 0);
    chk("pausedr_state", {28'b0, tap_state}, 32'h6);
    chk("pausedr_tdo_en", {31'b0, reg_tdo_en}, 32'h0);
    tick(1, 0);
    exp_q.push_back(1'b1);
    tick(0, 0);
    chk("resume_state", {28'b0, tap_state}, 32'h4);
    sb_empty("resume_bits");

    // Five TMS=1 from ShDR reach TLR
    for (int i = 0; i < 4; i++) tick(1, 0);
    chk("tms4_state", {28'b0, tap_state}, 32'h9);
    tick(1, 0);
    chk("tlr_state", {28'b0, tap_state}, 32'h0);
    chk("tlr_ir", {28'b0, ir_active}, 32'h2);
    chk("tlr_strobes", {27'b0, idcode_capture_en, idcode_shift_enable,
                        user_capture_en, user_shift_enable, user_update_en}, 32'h0);

    // Reset in the middle of an IR shift
    tick(0, 0); tick(1, 0); tick(1, 0); tick(0, 0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    tick(0, 0); tick(0, 1); tick(0, 1);
    sb_empty("midrst_bits");
    #2 reg_rst_n = 1'b0;
    #1;
    chk("midrst_state", {28'b0, tap_state}, 32'h0);
    chk("midrst_ir", {28'b0, ir_active}, 32'h2);
    chk("midrst_tdo_en", {31'b0, reg_tdo_en}, 32'h0);
    @(negedge reg_tck); #1;
    reg_rst_n = 1'b1;
    tick(1, 0);
    chk("postrst_ir", {28'b0, ir_active}, 32'h2);

    // IR = 1000: USER register when built in, BYPASS otherwise
    tick(0, 0); tick(1, 0); tick(1, 0); tick(0, 0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    tick(0, 0);
    tick(0, 0); tick(0, 0); tick(0, 0); tick(1, 1);
    tick(1, 0);
    chk("ir_user", {28'b0, ir_active}, 32'h8);
    sb_empty("user_ircap_bits");
    tick(1, 0); tick(0, 0);
    chk("user_cap_en", {31'b0, user_capture_en}, {31'b0, USER_EN});
    chk("user_id_cap", {31'b0, idcode_capture_en}, 32'h0);
    if (USER_EN) begin
      exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    end else begin
      exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    end
    tick(0, 0);
    chk("user_sh_en", {31'b0, user_shift_enable}, {31'b0, USER_EN});
    tick(0, 1); tick(0, 0); tick(1, 0);
    tick(1, 0);
    chk("upddr_state", {28'b0, tap_state}, 32'h8);
    chk("user_upd_en", {31'b0, user_update_en}, {31'b0, USER_EN});
    tick(0, 0);
    chk("user_upd_clr", {31'b0, user_update_en}, 32'h0);
    sb_empty("user_dr_bits");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
